// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared by the ALU control decoder and the execute stage.
package alu_pkg;
    typedef logic [3:0] alu_ctrl_t;
    localparam alu_ctrl_t ALU_ADD = 4'd0;
    localparam alu_ctrl_t ALU_SUB = 4'd1;
    localparam alu_ctrl_t ALU_AND = 4'd2;
    localparam alu_ctrl_t ALU_ORR = 4'd3;
    localparam alu_ctrl_t ALU_NOT = 4'd4;
    localparam alu_ctrl_t ALU_TCP = 4'd5;
    localparam alu_ctrl_t ALU_SHL = 4'd6;
    localparam alu_ctrl_t ALU_SHR = 4'd7;
    localparam alu_ctrl_t ALU_LHI = 4'd8;
    localparam alu_ctrl_t ALU_WWD = 4'd13;
    localparam alu_ctrl_t ALU_HLT = 4'd15;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU, maps control code and operands to a result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  alu_ctrl_t         alu_ctrl,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] result
);
    localparam int HALF = WORD_W / 2;
    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_NOT: result = ~a;
            ALU_TCP: result = -a;
            ALU_SHL: result = {a[WORD_W-2:0], 1'b0};
            ALU_SHR: result = {a[WORD_W-1], a[WORD_W-1:1]};
            ALU_LHI: result = {b[HALF-1:0], {HALF{1'b0}}};
            ALU_WWD: result = a;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: EX stage with EX/MEM register, WWD output port and HLT latch.
// Define ALU_FLAGS_EN to add registered out_zero/out_neg flags.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_ctrl_t             alu_ctrl,
    input  logic [WORD_W-1:0]     op_a,
    input  logic [WORD_W-1:0]     op_b,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_wb_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W-1:0]     out_result,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  out_wb_en,
    output logic [WORD_W-1:0]     output_port,
    output logic                  halted
`ifdef ALU_FLAGS_EN
    ,
    output logic                  out_zero,
    output logic                  out_neg
`endif
);
    logic [WORD_W-1:0] result;
    logic              accept;
    logic              side;
    alu_core #(.WORD_W(WORD_W)) u_core (
        .alu_ctrl(alu_ctrl),
        .a(op_a),
        .b(op_b),
        .result(result)
    );
    assign in_ready = ~halted & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign side     = (alu_ctrl == ALU_WWD) || (alu_ctrl == ALU_HLT);
    // Data registers load only on accept so a stalled entry stays stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_dest    <= '0;
            out_wb_en   <= 1'b0;
            output_port <= '0;
            halted      <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_dest   <= in_dest;
            out_wb_en  <= in_wb_en & ~side;
            if (alu_ctrl == ALU_WWD) output_port <= op_a;
            if (alu_ctrl == ALU_HLT) halted <= 1'b1;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end
`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (accept) begin
            out_zero <= (result == '0);
            out_neg  <= result[WORD_W-1];
        end
    end
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized check of alu_exec_stage against a behavioural model plus directed cases.
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [1:0]  in_dest;
    logic        in_wb_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [1:0]  out_dest;
    logic        out_wb_en;
    logic [15:0] output_port;
    logic        halted;
`ifdef ALU_FLAGS_EN
    logic        out_zero;
    logic        out_neg;
`endif
    int errors = 0;
    int checks = 0;

    alu_exec_stage #(.WORD_W(16), .REG_ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .in_dest(in_dest), .in_wb_en(in_wb_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dest(out_dest),
        .out_wb_en(out_wb_en), .output_port(output_port), .halted(halted)
`ifdef ALU_FLAGS_EN
        , .out_zero(out_zero), .out_neg(out_neg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        case (c)
            4'd0:  r = a + b;
            4'd1:  r = 32'(a) + 32'h10000 - 32'(b);
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = 32'hFFFF - 32'(a);
            4'd5:  r = 32'h10000 - 32'(a);
            4'd6:  r = 32'(a) * 2;
            4'd7:  r = 32'(a / 2) + (a >= 16'h8000 ? 32'h8000 : 32'h0);
            4'd8:  r = 32'(b % 256) * 256;
            4'd13: r = 32'(a);
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    logic        m_valid, m_wb, m_halted;
    logic [15:0] m_res, m_port;
    logic [1:0]  m_dest;
    wire         m_ready = !m_halted && (!m_valid || out_ready);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 0; m_res <= 0; m_dest <= 0; m_wb <= 0; m_port <= 0; m_halted <= 0;
        end else if (in_valid && m_ready && !flush) begin
            m_valid <= 1;
            m_res   <= ref_result(alu_ctrl, op_a, op_b);
            m_dest  <= in_dest;
            m_wb    <= (alu_ctrl == 13 || alu_ctrl == 15) ? 1'b0 : in_wb_en;
            if (alu_ctrl == 13) m_port <= op_a;
            if (alu_ctrl == 15) m_halted <= 1;
        end else if (flush || out_ready) begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", 16'(in_ready), 16'(m_ready));
            chk("out_valid", 16'(out_valid), 16'(m_valid));
            chk("output_port", output_port, m_port);
            chk("halted", 16'(halted), 16'(m_halted));
            if (m_valid) begin
                chk("out_result", out_result, m_res);
                chk("out_dest", 16'(out_dest), 16'(m_dest));
                chk("out_wb_en", 16'(out_wb_en), 16'(m_wb));
`ifdef ALU_FLAGS_EN
                chk("out_zero", 16'(out_zero), 16'(m_res == 0));
                chk("out_neg", 16'(out_neg), 16'(m_res[15]));
`endif
            end
        end
    end

    task automatic next;
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp, input string name);
        alu_ctrl = c; op_a = a; op_b = b; in_dest = 2'd1; in_wb_en = 1; in_valid = 1; out_ready = 1;
        next();
        in_valid = 0;
        chk({name, "_valid"}, 16'(out_valid), 16'd1);
        chk(name, out_result, exp);
    endtask

    initial begin
        reset_n = 0; flush = 0; in_valid = 0; alu_ctrl = 0; op_a = 0; op_b = 0;
        in_dest = 0; in_wb_en = 0; out_ready = 0;
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_result", out_result, 16'h0000);
        chk("rst_output_port", output_port, 16'h0000);
        chk("rst_halted", 16'(halted), 16'd0);
        next();
        reset_n = 1;
        op(4'd0, 16'h7FFF, 16'h0001, 16'h8000, "add");
`ifdef ALU_FLAGS_EN
        chk("add_neg", 16'(out_neg), 16'd1);
        chk("add_zero", 16'(out_zero), 16'd0);
`endif
        op(4'd1, 16'h0003, 16'h0005, 16'hFFFE, "sub");
        op(4'd5, 16'h0001, 16'h0000, 16'hFFFF, "tcp");
        op(4'd7, 16'h8004, 16'h0000, 16'hC002, "shr");
        op(4'd8, 16'h0000, 16'h00AB, 16'hAB00, "lhi");
        op(4'd13, 16'h1234, 16'h0000, 16'h1234, "wwd");
        chk("wwd_port", output_port, 16'h1234);
        chk("wwd_wb_en", 16'(out_wb_en), 16'd0);
        alu_ctrl = 13; op_a = 16'h5555; in_valid = 1; flush = 1;
        next();
        flush = 0; in_valid = 0;
        chk("flush_port", output_port, 16'h1234);
        chk("flush_valid", 16'(out_valid), 16'd0);
        // Back-to-back ADDs behind a three-cycle stall.
        out_ready = 0; alu_ctrl = 0; op_a = 1; op_b = 2; in_valid = 1;
        next();
        op_a = 3; op_b = 4;
        for (int i = 0; i < 3; i++) begin
            next();
            chk("stall_in_ready", 16'(in_ready), 16'd0);
            chk("stall_hold", out_result, 16'h0003);
        end
        out_ready = 1;
        next();
        in_valid = 0;
        chk("replace_valid", 16'(out_valid), 16'd1);
        chk("second_result", out_result, 16'h0007);
        next();
        chk("drained", 16'(out_valid), 16'd0);
        for (int i = 0; i < 2000; i++) begin
            alu_ctrl  = 4'($urandom_range(0, 14));
            op_a      = 16'($urandom);
            op_b      = 16'($urandom);
            in_dest   = 2'($urandom);
            in_wb_en  = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 7) == 0);
            next();
        end
        flush = 0; in_valid = 0;
        // Asynchronous reset while a stalled entry is held.
        out_ready = 0; alu_ctrl = 0; op_a = 9; op_b = 9; in_valid = 1;
        next();
        in_valid = 0;
        chk("pre_rst_valid", 16'(out_valid), 16'd1);
        #1 reset_n = 0;
        #1 chk("async_rst_valid", 16'(out_valid), 16'd0);
        next();
        reset_n = 1;
        op(4'd15, 16'h1111, 16'h2222, 16'h0000, "hlt");
        chk("hlt_halted", 16'(halted), 16'd1);
        chk("hlt_wb_en", 16'(out_wb_en), 16'd0);
        chk("hlt_in_ready", 16'(in_ready), 16'd0);
        alu_ctrl = 0; op_a = 16'h0101; op_b = 16'h0101; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            next();
            chk("halt_ignored", 16'(out_valid), 16'd0);
            chk("halt_result_held", out_result, 16'h0000);
        end
        in_valid = 0;
        #1 reset_n = 0;
        #1;
        chk("unhalt", 16'(halted), 16'd0);
        chk("unhalt_in_ready", 16'(in_ready), 16'd1);
        next();
        reset_n = 1;
        next();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
